regfile_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_ldext.sv | 62 ++++++
 rtl/regfile_sb.sv | 109 ++++++++++
 tb/tb_regfile_sb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared types and constants for the scoreboarded register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   // RISC-V funct3 load/store type codes
   typedef enum logic [2:0] {
      LST_SB = 3'b000,
      LST_SH = 3'b001,
      LST_SW = 3'b010,
      LST_SD = 3'b011,
      LST_UB = 3'b100,
      LST_UH = 3'b101,
      LST_UW = 3'b110,
      LST_UD = 3'b111
   } lst_e;

   localparam int XLEN_32 = 32;
   localparam int XLEN_64 = 64;

   localparam logic [1:0] ST_BYTE = 2'b00;
   localparam logic [1:0] ST_HALF = 2'b01;
   localparam logic [1:0] ST_WORD = 2'b10;
   localparam logic [1:0] ST_FULL = 2'b11;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_ldext.sv
`default_nettype none
// ============================================================================
// Module   : regfile_ldext
// Purpose  : Load writeback extension (i_store=0) or store truncation (i_store=1).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_ldext
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_32
) (
   input  logic [XLEN-1:0] i_data,
   input  logic [2:0]      i_lst,
   input  logic            i_lse,
   input  logic            i_store,
   output logic [XLEN-1:0] o_data
);

   logic [XLEN-1:0] w_sb, w_sh, w_sw, w_zb, w_zh, w_zw;

   assign w_sb = {{(XLEN-8){i_data[7]}}, i_data[7:0]};
   assign w_sh = {{(XLEN-16){i_data[15]}}, i_data[15:0]};
   assign w_zb = {{(XLEN-8){1'b0}}, i_data[7:0]};
   assign w_zh = {{(XLEN-16){1'b0}}, i_data[15:0]};

   // Word extension only exists when the datapath is wider than a word
   generate
      if (XLEN > 32) begin : g_word_ext
         assign w_sw = {{(XLEN-32){i_data[31]}}, i_data[31:0]};
         assign w_zw = {{(XLEN-32){1'b0}}, i_data[31:0]};
      end else begin : g_word_pass
         assign w_sw = i_data;
         assign w_zw = i_data;
      end
   endgenerate

   always_comb begin
      o_data = i_data;
      if (i_lse) begin
         if (i_store) begin
            case (i_lst[1:0])
               ST_BYTE: o_data = w_zb;
               ST_HALF: o_data = w_zh;
               ST_WORD: o_data = w_zw;
               default: o_data = i_data;
            endcase
         end else begin
            case (lst_e'(i_lst))
               LST_SB:  o_data = w_sb;
               LST_SH:  o_data = w_sh;
               LST_SW:  o_data = w_sw;
               LST_UB:  o_data = w_zb;
               LST_UH:  o_data = w_zh;
               LST_UW:  o_data = w_zw;
               default: o_data = i_data;
            endcase
         end
      end
   end

endmodule : regfile_ldext
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Parametrised register file with busy scoreboard; optional
//            same-cycle writeback bypass under REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [AW-1:0]   A1,
   input  logic [AW-1:0]   A2,
   output logic [XLEN-1:0] RD1,
   output logic [XLEN-1:0] RD2,
   output logic            RDY1,
   output logic            RDY2,
   input  logic            ISSUE,
   input  logic [AW-1:0]   ISSUE_RD,
   input  logic            WE3,
   input  logic [AW-1:0]   A3,
   input  logic [XLEN-1:0] WD3,
   input  logic [2:0]      LST,
   input  logic            LSE,
   output logic [AW:0]     BUSY_CNT
);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [NREGS-1:0] r_busy;
   logic [AW:0]      r_busy_cnt;

   logic [XLEN-1:0]  w_wb_data, w_st1, w_st2, w_rd1, w_rd2_raw;
   logic             w_wb_hit, w_iss_hit, w_set, w_clr, w_rdy1, w_rdy2;

   regfile_ldext #(.XLEN(XLEN)) u_wb_ext (
      .i_data  (WD3),
      .i_lst   (LST),
      .i_lse   (LSE),
      .i_store (1'b0),
      .o_data  (w_wb_data)
   );

   assign w_wb_hit  = WE3 && (A3 != '0);
   assign w_iss_hit = ISSUE && (ISSUE_RD != '0);
   // Count moves only on real busy transitions; issue beats same-register writeback
   assign w_set = w_iss_hit && !r_busy[ISSUE_RD];
   assign w_clr = w_wb_hit && r_busy[A3] && !(w_iss_hit && (ISSUE_RD == A3));

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         if (w_wb_hit) begin
            r_regs[A3] <= w_wb_data;
            r_busy[A3] <= 1'b0;
         end
         if (w_iss_hit) begin
            r_busy[ISSUE_RD] <= 1'b1;
         end
         case ({w_set, w_clr})
            2'b10:   r_busy_cnt <= r_busy_cnt + 1'b1;
            2'b01:   r_busy_cnt <= r_busy_cnt - 1'b1;
            default: r_busy_cnt <= r_busy_cnt;
         endcase
      end
   end

   assign w_st1 = (A1 == '0) ? '0 : r_regs[A1];
   assign w_st2 = (A2 == '0) ? '0 : r_regs[A2];

`ifdef REGFILE_BYPASS_EN
   logic w_byp1, w_byp2;
   assign w_byp1    = w_wb_hit && (A3 == A1);
   assign w_byp2    = w_wb_hit && (A3 == A2);
   assign w_rd1     = w_byp1 ? w_wb_data : w_st1;
   assign w_rd2_raw = w_byp2 ? w_wb_data : w_st2;
   assign w_rdy1    = w_byp1 || !r_busy[A1];
   assign w_rdy2    = w_byp2 || !r_busy[A2];
`else
   assign w_rd1     = w_st1;
   assign w_rd2_raw = w_st2;
   assign w_rdy1    = !r_busy[A1];
   assign w_rdy2    = !r_busy[A2];
`endif

   regfile_ldext #(.XLEN(XLEN)) u_st_trunc (
      .i_data  (w_rd2_raw),
      .i_lst   (LST),
      .i_lse   (LSE),
      .i_store (1'b1),
      .o_data  (RD2)
   );

   assign RD1      = w_rd1;
   assign RDY1     = w_rdy1;
   assign RDY2     = w_rdy2;
   assign BUSY_CNT = r_busy_cnt;

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Self-checking bench for regfile_sb (XLEN=32, NREGS=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

   logic        CLK, RST_N;
   logic [4:0]  A1, A2, ISSUE_RD, A3;
   logic [31:0] RD1, RD2, WD3;
   logic        RDY1, RDY2, ISSUE, WE3, LSE;
   logic [2:0]  LST;
   logic [5:0]  BUSY_CNT;

   regfile_sb dut (
      .CLK(CLK), .RST_N(RST_N), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
      .RDY1(RDY1), .RDY2(RDY2), .ISSUE(ISSUE), .ISSUE_RD(ISSUE_RD),
      .WE3(WE3), .A3(A3), .WD3(WD3), .LST(LST), .LSE(LSE), .BUSY_CNT(BUSY_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst_n;
      logic        issue;
      logic [4:0]  ird;
      logic        we3;
      logic [4:0]  a3;
      logic [31:0] wd3;
      logic [2:0]  lst;
      logic        lse;
      logic [4:0]  a1, a2;
      logic [31:0] e_rd1, e_rd2;
      logic        e_rdy1, e_rdy2;
      logic [5:0]  e_cnt;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_regs [32];
   bit   [31:0] m_busy;

   function automatic logic [31:0] m_ext(logic [31:0] d, logic [2:0] lst, logic lse);
      if (!lse) return d;
      case (lst)
         3'd0:    return 32'($signed(d[7:0]));
         3'd1:    return 32'($signed(d[15:0]));
         3'd4:    return d % 32'h100;
         3'd5:    return d % 32'h10000;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] m_st(logic [31:0] d, logic [2:0] lst, logic lse);
      if (!lse) return d;
      case (lst[1:0])
         2'd0:    return d % 32'h100;
         2'd1:    return d % 32'h10000;
         default: return d;
      endcase
   endfunction

   function automatic vec_t mk(logic iss, logic [4:0] ird, logic we, logic [4:0] a3,
                               logic [31:0] wd, logic [2:0] lst, logic lse,
                               logic [4:0] a1, logic [4:0] a2, logic [31:0] r1,
                               logic [31:0] r2, logic y1, logic y2, logic [5:0] c);
      vec_t t;
      t.rst_n = 1'b1; t.issue = iss; t.ird = ird; t.we3 = we; t.a3 = a3;
      t.wd3 = wd; t.lst = lst; t.lse = lse; t.a1 = a1; t.a2 = a2;
      t.e_rd1 = r1; t.e_rd2 = r2; t.e_rdy1 = y1; t.e_rdy2 = y2; t.e_cnt = c;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      RST_N = v.rst_n; ISSUE = v.issue; ISSUE_RD = v.ird; WE3 = v.we3; A3 = v.a3;
      WD3 = v.wd3; LST = v.lst; LSE = v.lse; A1 = v.a1; A2 = v.a2;
   endtask

   task automatic model_step(input vec_t v);
      if (!v.rst_n) begin
         foreach (m_regs[i]) m_regs[i] = '0;
         m_busy = '0;
      end else begin
         if (v.we3 && v.a3 != 0) begin
            m_regs[v.a3] = m_ext(v.wd3, v.lst, v.lse);
            m_busy[v.a3] = 1'b0;
         end
         if (v.issue && v.ird != 0) m_busy[v.ird] = 1'b1;
      end
   endtask

   task automatic model_check(input vec_t v, input string tag);
      logic [31:0] r1, r2;
      logic        y1, y2, b1, b2;
      b1 = 1'b0; b2 = 1'b0;
`ifdef REGFILE_BYPASS_EN
      b1 = v.we3 && v.a3 != 0 && v.a3 == v.a1;
      b2 = v.we3 && v.a3 != 0 && v.a3 == v.a2;
`endif
      r1 = b1 ? m_ext(v.wd3, v.lst, v.lse) : (v.a1 == 0 ? 32'h0 : m_regs[v.a1]);
      r2 = b2 ? m_ext(v.wd3, v.lst, v.lse) : (v.a2 == 0 ? 32'h0 : m_regs[v.a2]);
      r2 = m_st(r2, v.lst, v.lse);
      y1 = b1 || v.a1 == 0 || !m_busy[v.a1];
      y2 = b2 || v.a2 == 0 || !m_busy[v.a2];
      chk({tag, " rd1"}, 64'(RD1), 64'(r1));
      chk({tag, " rd2"}, 64'(RD2), 64'(r2));
      chk({tag, " rdy1"}, 64'(RDY1), 64'(y1));
      chk({tag, " rdy2"}, 64'(RDY2), 64'(y2));
      chk({tag, " cnt"}, 64'(BUSY_CNT), 64'($countones(m_busy)));
   endtask

   task automatic run_cycle(input vec_t v, input bit use_tab, input string tag);
      drive(v);
      @(negedge CLK);
      if (use_tab) begin
         chk({tag, " rd1"}, 64'(RD1), 64'(v.e_rd1));
         chk({tag, " rd2"}, 64'(RD2), 64'(v.e_rd2));
         chk({tag, " rdy1"}, 64'(RDY1), 64'(v.e_rdy1));
         chk({tag, " rdy2"}, 64'(RDY2), 64'(v.e_rdy2));
         chk({tag, " cnt"}, 64'(BUSY_CNT), 64'(v.e_cnt));
      end else begin
         model_check(v, tag);
      end
      @(posedge CLK);
      model_step(v);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   vec_t tab [23];
   vec_t v;

   initial begin
      // Rows: iss,ird,we,a3,wd3,lst,lse,a1,a2 | rd1,rd2,rdy1,rdy2,cnt (sampled before the edge)
      tab[0]  = mk(0,0, 1,5, 32'h000000F0,3'b000,1, 0,0,  32'h0,32'h0,1,1,0);
      tab[1]  = mk(0,0, 0,0, 32'h0,3'b000,0,        5,5,  32'hFFFFFFF0,32'hFFFFFFF0,1,1,0);
      tab[2]  = mk(0,0, 1,5, 32'h000000F0,3'b100,1, 6,0,  32'h0,32'h0,1,1,0);
      tab[3]  = mk(0,0, 0,0, 32'h0,3'b000,0,        5,0,  32'h000000F0,32'h0,1,1,0);
      tab[4]  = mk(0,0, 1,6, 32'h00008001,3'b001,1, 0,0,  32'h0,32'h0,1,1,0);
      tab[5]  = mk(0,0, 0,0, 32'h0,3'b000,0,        6,6,  32'hFFFF8001,32'hFFFF8001,1,1,0);
      tab[6]  = mk(0,0, 1,7, 32'h12345678,3'b001,0, 0,0,  32'h0,32'h0,1,1,0);
      tab[7]  = mk(0,0, 0,0, 32'h0,3'b001,1,        7,7,  32'h12345678,32'h00005678,1,1,0);
      tab[8]  = mk(0,0, 0,0, 32'h0,3'b000,1,        7,7,  32'h12345678,32'h00000078,1,1,0);
      tab[9]  = mk(0,0, 0,0, 32'h0,3'b010,1,        6,7,  32'hFFFF8001,32'h12345678,1,1,0);
      tab[10] = mk(1,3, 0,0, 32'h0,3'b000,0,        3,0,  32'h0,32'h0,1,1,0);
      tab[11] = mk(0,0, 0,0, 32'h0,3'b000,0,        3,3,  32'h0,32'h0,0,0,1);
      tab[12] = mk(1,9, 0,0, 32'h0,3'b000,0,        9,0,  32'h0,32'h0,1,1,1);
      tab[13] = mk(0,0, 0,0, 32'h0,3'b000,0,        9,3,  32'h0,32'h0,0,0,2);
      tab[14] = mk(1,9, 1,9, 32'h00000055,3'b000,0, 3,0,  32'h0,32'h0,0,1,2);
      tab[15] = mk(1,0, 0,0, 32'h0,3'b000,0,        9,9,  32'h55,32'h55,0,0,2);
      tab[16] = mk(0,0, 0,0, 32'h0,3'b000,0,        0,0,  32'h0,32'h0,1,1,2);
      tab[17] = mk(0,0, 1,3, 32'h000000AB,3'b000,0, 5,9,  32'hF0,32'h55,1,0,2);
      tab[18] = mk(0,0, 0,0, 32'h0,3'b000,0,        3,9,  32'hAB,32'h55,1,0,1);
      tab[19] = mk(0,0, 1,10,32'h00000001,3'b000,0, 0,0,  32'h0,32'h0,1,1,1);
      tab[20] = mk(0,0, 0,0, 32'h0,3'b000,0,        10,9, 32'h1,32'h55,1,0,1);
      tab[21] = mk(0,0, 1,0, 32'h0000FFFF,3'b000,0, 0,0,  32'h0,32'h0,1,1,1);
      tab[22] = mk(0,0, 0,0, 32'h0,3'b000,0,        0,10, 32'h0,32'h1,1,1,1);

      // Reset with stray ISSUE/WE3 present
      v = mk(1,4, 1,4, 32'hDEADBEEF,3'b000,0, 0,0, 0,0,0,0,0);
      v.rst_n = 1'b0;
      drive(v);
      @(posedge CLK); @(posedge CLK);
      model_step(v);
      #1;
      v = mk(0,0, 0,0, 32'h0,3'b000,0, 0,0, 0,0,0,0,0);
      drive(v);
      for (int a = 0; a < 32; a++) begin
         A1 = 5'(a); A2 = 5'(31 - a);
         #1;
         chk($sformatf("reset rd1[%0d]", a), 64'(RD1), 64'h0);
         chk($sformatf("reset rd2[%0d]", 31 - a), 64'(RD2), 64'h0);
         chk($sformatf("reset rdy1[%0d]", a), 64'(RDY1), 64'h1);
         chk($sformatf("reset rdy2[%0d]", 31 - a), 64'(RDY2), 64'h1);
      end
      chk("reset cnt", 64'(BUSY_CNT), 64'h0);

      for (int i = 0; i < 23; i++) run_cycle(tab[i], 1'b1, $sformatf("tab%0d", i));

      // Issue x3, writeback four cycles later
      run_cycle(mk(1,3, 0,0, 32'h0,3'b000,0, 3,0, 0,0,0,0,0), 1'b0, "lat c0");
      for (int c = 1; c < 4; c++)
         run_cycle(mk(0,0, 0,0, 32'h0,3'b000,0, 3,0, 0,0,0,0,0), 1'b0, $sformatf("lat c%0d", c));
      v = mk(0,0, 1,3, 32'h00000077,3'b000,0, 3,0, 0,0,0,0,0);
      drive(v);
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("lat c4 rdy1", 64'(RDY1), 64'h1);
      chk("lat c4 rd1", 64'(RD1), 64'h77);
`else
      chk("lat c4 rdy1", 64'(RDY1), 64'h0);
      chk("lat c4 rd1", 64'(RD1), 64'hAB);
`endif
      chk("lat c4 cnt", 64'(BUSY_CNT), 64'h2);
      run_cycle(v, 1'b0, "lat c4");
      run_cycle(mk(0,0, 0,0, 32'h0,3'b000,0, 3,0, 0,0,0,0,0), 1'b0, "lat c5");
      chk("lat c5 cnt", 64'(BUSY_CNT), 64'h1);

      // Busy x1, x2 then reset together with a writeback to x4
      run_cycle(mk(1,1, 0,0, 32'h0,3'b000,0, 1,0, 0,0,0,0,0), 1'b0, "rst i1");
      run_cycle(mk(1,2, 0,0, 32'h0,3'b000,0, 1,2, 0,0,0,0,0), 1'b0, "rst i2");
      v = mk(0,0, 1,4, 32'h0000BEEF,3'b000,0, 1,2, 0,0,0,0,0);
      v.rst_n = 1'b0;
      run_cycle(v, 1'b0, "rst wb");
      v = mk(0,0, 0,0, 32'h0,3'b000,0, 4,1, 0,0,0,0,0);
      drive(v);
      #1;
      chk("post-rst cnt", 64'(BUSY_CNT), 64'h0);
      chk("post-rst x4", 64'(RD1), 64'h0);
      chk("post-rst rdy x1", 64'(RDY2), 64'h1);

      // Randomised traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         v = mk($urandom_range(0,1), 5'($urandom), $urandom_range(0,1), 5'($urandom),
                $urandom, 3'($urandom), $urandom_range(0,1), 5'($urandom), 5'($urandom),
                0,0,0,0,0);
         v.rst_n = ($urandom_range(0,59) != 0);
         if ($urandom_range(0,3) == 0) v.a1 = v.a3;
         if ($urandom_range(0,3) == 0) v.ird = v.a3;
         run_cycle(v, 1'b0, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_regfile_sb
`default_nettype wire
